// File: rtl/frame_sync_rx_if.sv
// Bit-stream input and packed-word output bundle for the RX deframer.
// slave: the deframer side; master: demodulator/FIFO side.
interface frame_sync_rx_if #(
  parameter int unsigned OUT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/frame_sync_rx.sv
// Receive-side deframer for the 1-bit SDR link. Hunts for a 6-bit all-zero
// (data) or all-one (idle) header, confirms alignment, then packs data-frame
// payload MSB-first into words for the RX FIFO.
// Optional build macro RX_BER_CHECK_EN: counts idle-payload bit errors against
// the transmit idle pattern; when undefined ber_err_cnt is tied to 0.
module frame_sync_rx #(
  parameter int unsigned HDR_LEN      = 6,
  parameter int unsigned PAYLOAD_LEN  = 96,
  parameter int unsigned OUT_WIDTH    = 32,
  parameter int unsigned LOCK_CONFIRM = 2,
  parameter int unsigned MISS_LIMIT   = 3
) (
  input  logic           clk,
  input  logic           rst,
  frame_sync_rx_if.slave bus,
  output logic           locked,
  output logic [15:0]    sync_loss_cnt,
  output logic [15:0]    overflow_cnt,
  output logic [15:0]    ber_err_cnt
);
  localparam int unsigned CNT_LEN = (PAYLOAD_LEN > HDR_LEN) ? PAYLOAD_LEN : HDR_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_LEN);
  localparam int unsigned PK_W    = $clog2(OUT_WIDTH);
  localparam int unsigned CONF_W  = $clog2(LOCK_CONFIRM + 1);
  localparam int unsigned MISS_W  = $clog2(MISS_LIMIT + 1);

  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [PK_W-1:0]  PACK_LAST = PK_W'(OUT_WIDTH - 1);

  localparam logic [2:0] ST_HUNT     = 3'd0;
  localparam logic [2:0] ST_CONF_PAY = 3'd1;
  localparam logic [2:0] ST_CONF_HDR = 3'd2;
  localparam logic [2:0] ST_LOCK_PAY = 3'd3;
  localparam logic [2:0] ST_LOCK_HDR = 3'd4;

  localparam logic [1:0] FT_DATA    = 2'd0;
  localparam logic [1:0] FT_IDLE    = 2'd1;
  localparam logic [1:0] FT_UNKNOWN = 2'd2;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]           state_q, state_d;
  logic [HDR_LEN-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CONF_W-1:0]    conf_cnt_q, conf_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [1:0]           ftype_q, ftype_d;
  logic [OUT_WIDTH-1:0] pack_q, pack_d;
  logic [PK_W-1:0]      pack_cnt_q, pack_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]          sync_loss_q, sync_loss_d;
  logic [15:0]          overflow_q, overflow_d;

  logic [HDR_LEN-1:0]   hdr_word;
  logic                 hdr_zero, hdr_one, hdr_ok;
  logic [OUT_WIDTH-1:0] pack_shift;
  logic                 word_done;

  // Window ending on the current bit; used both for hunting and header checks.
  assign hdr_word   = {shift_q[HDR_LEN-2:0], bus.in_data};
  assign hdr_zero   = (hdr_word == '0);
  assign hdr_one    = &hdr_word;
  assign hdr_ok     = hdr_zero | hdr_one;
  assign pack_shift = {pack_q[OUT_WIDTH-2:0], bus.in_data};

  // Alignment FSM, payload packing and one-word output buffer.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    conf_cnt_d  = conf_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ftype_d     = ftype_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sync_loss_d = sync_loss_q;
    overflow_d  = overflow_q;
    word_done   = 1'b0;

    if (bus.in_valid) begin
      shift_d   = hdr_word;
      bit_cnt_d = bit_cnt_q + 1'b1;
      case (state_q)
        ST_HUNT: begin
          bit_cnt_d = '0;
          if (hdr_ok) begin
            state_d    = ST_CONF_PAY;
            conf_cnt_d = '0;
          end
        end
        ST_CONF_PAY: begin
          if (bit_cnt_q == PAY_LAST) begin
            state_d   = ST_CONF_HDR;
            bit_cnt_d = '0;
          end
        end
        ST_CONF_HDR: begin
          if (bit_cnt_q == HDR_LAST) begin
            bit_cnt_d = '0;
            if (hdr_ok) begin
              conf_cnt_d = conf_cnt_q + 1'b1;
              ftype_d    = hdr_one ? FT_IDLE : FT_DATA;
              if (conf_cnt_d == CONF_W'(LOCK_CONFIRM)) begin
                state_d    = ST_LOCK_PAY;
                miss_cnt_d = '0;
                pack_cnt_d = '0;
              end else begin
                state_d = ST_CONF_PAY;
              end
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        ST_LOCK_PAY: begin
          // Idle and unknown payload is simply not packed.
          if (ftype_q == FT_DATA) begin
            pack_d     = pack_shift;
            pack_cnt_d = pack_cnt_q + 1'b1;
            if (pack_cnt_q == PACK_LAST) begin
              word_done  = 1'b1;
              pack_cnt_d = '0;
            end
          end
          if (bit_cnt_q == PAY_LAST) begin
            state_d   = ST_LOCK_HDR;
            bit_cnt_d = '0;
          end
        end
        ST_LOCK_HDR: begin
          if (bit_cnt_q == HDR_LAST) begin
            bit_cnt_d = '0;
            if (hdr_ok) begin
              miss_cnt_d = '0;
              ftype_d    = hdr_one ? FT_IDLE : FT_DATA;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
              ftype_d    = FT_UNKNOWN;
            end
            if (miss_cnt_d == MISS_W'(MISS_LIMIT)) begin
              state_d     = ST_HUNT;
              miss_cnt_d  = '0;
              sync_loss_d = sat_inc(sync_loss_q);
              pack_d      = '0;
              pack_cnt_d  = '0;
            end else begin
              state_d = ST_LOCK_PAY;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // A pop in the same cycle frees the buffer for a completing word.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (word_done) begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = pack_shift;
      end else begin
        overflow_d = sat_inc(overflow_q);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      conf_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      ftype_q     <= FT_UNKNOWN;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sync_loss_q <= '0;
      overflow_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      conf_cnt_q  <= conf_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      ftype_q     <= ftype_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sync_loss_q <= sync_loss_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef RX_BER_CHECK_EN
  logic [15:0] ber_q, ber_d;

  // Idle payload bit k is expected to equal k[1] (0,0,1,1,...).
  always_comb begin
    ber_d = ber_q;
    if (bus.in_valid && (state_q == ST_LOCK_PAY) && (ftype_q == FT_IDLE) &&
        (bus.in_data != bit_cnt_q[1])) begin
      ber_d = sat_inc(ber_q);
    end
  end

  // Bit-error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ber_q <= '0;
    end else begin
      ber_q <= ber_d;
    end
  end

  assign ber_err_cnt = ber_q;
`else
  assign ber_err_cnt = 16'd0;
`endif

  assign bus.in_ready   = 1'b1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign locked         = (state_q == ST_LOCK_PAY) || (state_q == ST_LOCK_HDR);
  assign sync_loss_cnt  = sync_loss_q;
  assign overflow_cnt   = overflow_q;
endmodule

// File: tb/tb_frame_sync_rx.sv
// Self-checking bench for frame_sync_rx: table-driven lock/pack scenarios,
// hand-written sync-loss / bit-error / mid-frame reset sequences, and a
// randomized frame stream checked against a frame-level reference model.
module tb_frame_sync_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        locked;
  logic [15:0] sync_loss_cnt, overflow_cnt, ber_err_cnt;

  frame_sync_rx_if #(.OUT_WIDTH(32)) bus ();

  frame_sync_rx dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .locked        (locked),
    .sync_loss_cnt (sync_loss_cnt),
    .overflow_cnt  (overflow_cnt),
    .ber_err_cnt   (ber_err_cnt)
  );

  always #5 clk = ~clk;

`ifdef RX_BER_CHECK_EN
  localparam bit BER_ON = 1'b1;
`else
  localparam bit BER_ON = 1'b0;
`endif

  localparam logic [5:0] IDLE_HDR = 6'b111111;
  localparam logic [5:0] DATA_HDR = 6'b000000;
  localparam logic [5:0] BAD_HDR  = 6'b010101;

  int          n_vec = 0;
  int          n_err = 0;
  logic        rdy = 1'b1;
  bit          rand_rdy = 1'b0;
  bit          gaps = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  typedef struct {
    logic [95:0] pay;
    logic        rdy;
    int          exp_words;
    int          exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One clock: sample handshake for the coming edge, then drive inputs.
  task automatic cycle(input logic v, input logic d);
    @(negedge clk);
    if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
    bus.out_ready = rdy;
    bus.in_valid  = v;
    bus.in_data   = d;
    if (bus.out_valid && rdy && !rst) got_q.push_back(bus.out_data);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_bit(input logic d);
    int g;
    g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) cycle(1'b0, ~d);
    cycle(1'b1, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [95:0] idle_pay(input logic [95:0] flips);
    logic [95:0] p;
    for (int k = 0; k < 96; k++) p[95-k] = k[1];
    return p ^ flips;
  endfunction

  function automatic logic [95:0] alt_pay();
    logic [95:0] p;
    for (int k = 0; k < 96; k++) p[95-k] = ~k[0];
    return p;
  endfunction

  // lk_mode: 0 no check, 1 expect lock rise, 2 expect lock fall on this header.
  task automatic send_frame(input logic [5:0] hdr, input logic [95:0] pay, input int lk_mode);
    for (int i = 5; i >= 1; i--) send_bit(hdr[i]);
    if (lk_mode == 1) chk("locked_before_rise", 32'(locked), 32'd0);
    if (lk_mode == 2) chk("locked_before_fall", 32'(locked), 32'd1);
    send_bit(hdr[0]);
    if (lk_mode != 0) begin
      @(posedge clk);
      #1;
      chk(lk_mode == 1 ? "locked_rise" : "locked_fall", 32'(locked), 32'(lk_mode == 1));
    end
    for (int k = 95; k >= 0; k--) send_bit(pay[k]);
  endtask

  task automatic acquire();
    send_frame(IDLE_HDR, idle_pay('0), 0);
    send_frame(IDLE_HDR, idle_pay('0), 0);
    send_frame(IDLE_HDR, idle_pay('0), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[4];
    logic [95:0] pay, flips;
    logic [5:0]  hdr;
    int          miss_run, kind, nflip, ber_exp;

    vecs[0] = '{96'hDEADBEEF_01234567_89ABCDEF, 1'b1, 3, 0};
    vecs[1] = '{96'hDEADBEEF_01234567_89ABCDEF, 1'b0, 0, 2};
    vecs[2] = '{96'hFFFFFFFF_00000000_A5A5A5A5, 1'b1, 3, 0};
    vecs[3] = '{96'h13579BDF_2468ACE0_0F0F0F0F, 1'b0, 0, 2};

    bus.in_valid  = 1'b0;
    bus.in_data   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset and long quiet period.
    do_reset();
    idle(200);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_sync_loss", 32'(sync_loss_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow_cnt), 32'd0);
    chk("rst_ber", 32'(ber_err_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    gaps = 1'b1;

    // Table: lock on idle frames, then one data frame with ready held or free.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      rdy = 1'b1;
      got_q.delete();
      acquire();
      rdy = vecs[v].rdy;
      send_frame(DATA_HDR, vecs[v].pay, 0);
      idle(4);
      chk("tbl_word_count", 32'(got_q.size()), 32'(vecs[v].exp_words));
      for (int i = 0; i < got_q.size() && i < 3; i++)
        chk("tbl_word", got_q[i], vecs[v].pay[95-32*i -: 32]);
      chk("tbl_overflow", 32'(overflow_cnt), 32'(vecs[v].exp_ovf));
      if (!vecs[v].rdy) begin
        chk("held_valid", 32'(bus.out_valid), 32'd1);
        chk("held_data", bus.out_data, vecs[v].pay[95:64]);
        rdy = 1'b1;
        idle(5);
        chk("drain_handshakes", 32'(got_q.size()), 32'd1);
        chk("drain_word", got_q[0], vecs[v].pay[95:64]);
      end
      chk("tbl_valid_after", 32'(bus.out_valid), 32'd0);
    end

    // Sync loss after three bad headers, then relock.
    do_reset();
    rdy = 1'b1;
    got_q.delete();
    acquire();
    pay = {$urandom, $urandom, $urandom};
    send_frame(DATA_HDR, pay, 0);
    idle(3);
    chk("pre_loss_words", 32'(got_q.size()), 32'd3);
    got_q.delete();
    send_frame(BAD_HDR, {$urandom, $urandom, $urandom}, 0);
    send_frame(BAD_HDR, {$urandom, $urandom, $urandom}, 0);
    chk("locked_after_2_miss", 32'(locked), 32'd1);
    send_frame(BAD_HDR, alt_pay(), 2);
    chk("sync_loss_cnt", 32'(sync_loss_cnt), 32'd1);
    chk("no_words_bad_frames", 32'(got_q.size()), 32'd0);
    acquire();
    chk("sync_loss_after_relock", 32'(sync_loss_cnt), 32'd1);

    // Idle frame with five flipped payload bits.
    flips = '0;
    flips[92] = 1'b1;
    flips[70] = 1'b1;
    flips[41] = 1'b1;
    flips[40] = 1'b1;
    flips[3]  = 1'b1;
    send_frame(IDLE_HDR, idle_pay(flips), 0);
    idle(2);
    chk("ber_count", 32'(ber_err_cnt), BER_ON ? 32'd5 : 32'd0);

    // Reset 40 payload bits into a locked data frame with the first word buffered.
    got_q.delete();
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
    chk("buffered_before_rst", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", bus.out_data, 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_sync_loss", 32'(sync_loss_cnt), 32'd0);
    chk("midrst_overflow", 32'(overflow_cnt), 32'd0);
    chk("midrst_ber", 32'(ber_err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    rdy = 1'b1;
    idle(10);
    chk("midrst_no_word", 32'(got_q.size()), 32'd0);

    // Random frame stream against a frame-level model.
    do_reset();
    got_q.delete();
    exp_q.delete();
    rand_rdy = 1'b1;
    miss_run = 0;
    ber_exp  = 0;
    for (int f = 0; f < 30; f++) begin
      if (f == 0) kind = 1;
      else if (f < 3) kind = $urandom_range(0, 1);
      else kind = $urandom_range(0, (miss_run < 2) ? 2 : 1);
      nflip = 0;
      if (kind == 0) begin
        hdr = DATA_HDR;
        pay = {$urandom, $urandom, $urandom};
      end else if (kind == 1) begin
        hdr = IDLE_HDR;
        flips = '0;
        for (int k = 0; k < 96; k++) begin
          if ($urandom_range(0, 63) == 0) begin
            flips[k] = 1'b1;
            nflip++;
          end
        end
        pay = idle_pay(flips);
      end else begin
        do hdr = 6'($urandom); while (hdr == 6'h00 || hdr == 6'h3F);
        pay = {$urandom, $urandom, $urandom};
      end
      // Lock is confirmed on frame 2's header, so its payload is already live.
      if (f >= 2) begin
        if (kind == 0) begin
          exp_q.push_back(pay[95:64]);
          exp_q.push_back(pay[63:32]);
          exp_q.push_back(pay[31:0]);
        end else if (kind == 1) begin
          ber_exp += nflip;
        end
        miss_run = (kind == 2) ? miss_run + 1 : 0;
      end
      send_frame(hdr, pay, 0);
    end
    idle(40);
    rand_rdy = 1'b0;
    rdy = 1'b1;
    idle(5);
    chk("rand_word_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("rand_word", got_q[i], exp_q[i]);
    chk("rand_locked", 32'(locked), 32'd1);
    chk("rand_sync_loss", 32'(sync_loss_cnt), 32'd0);
    chk("rand_overflow", 32'(overflow_cnt), 32'd0);
    chk("rand_ber", 32'(ber_err_cnt), BER_ON ? 32'(ber_exp) : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
